riscv_lsu: RTL and testbench

Load/store unit for the single-cycle RISC-V core. It sits between execute and writeback (`riscv_wb`). It converts load/store instructions into a request/acknowledge transaction on the data-memory bus and stalls the core until the transaction finishes. It then presents sign/zero-extended load data, the ALU result and a load flag to writeback.

---
 rtl/riscv_lsu_pkg.sv | 35 +++
 rtl/riscv_lsu_if.sv | 23 ++
 rtl/riscv_lsu_align.sv | 52 +++++
 rtl/riscv_lsu.sv | 182 ++++++++++++++++++
 tb/tb_riscv_lsu.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the load/store unit.
package riscv_lsu_pkg;

    localparam int REG_W = 32;
    localparam int MEM_W = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } acc_size_e;

    // funct3[1:0] carries the access size; funct3[2] selects zero-extension.
    // The unused size code 11 is handled as a word access.
    function automatic acc_size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Request/acknowledge data-memory bus between the LSU and memory.
interface riscv_lsu_if;
    import riscv_lsu_pkg::*;

    logic             mem_req;
    logic             mem_we;
    logic [REG_W-1:0] mem_addr;
    logic [3:0]       mem_be;
    logic [MEM_W-1:0] mem_wdata;
    logic [MEM_W-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/riscv_lsu_align.sv
// Lane steering for both directions: byte enables and replicated store data
// going out, lane selection and sign/zero extension coming back.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [1:0]       addr_lo_i,
    input  logic [2:0]       funct3_i,
    input  logic [REG_W-1:0] wdata_raw_i,
    input  logic [MEM_W-1:0] rdata_raw_i,
    output logic [3:0]       be_o,
    output logic [MEM_W-1:0] wdata_o,
    output logic [MEM_W-1:0] rdata_o,
    output logic             misalign_o
);

    acc_size_e  size;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Decode size, then steer lanes and check natural alignment.
    always_comb begin
        size       = f3_size(funct3_i);
        byte_lane  = rdata_raw_i[{addr_lo_i, 3'b000} +: 8];
        half_lane  = addr_lo_i[1] ? rdata_raw_i[31:16] : rdata_raw_i[15:0];
        be_o       = 4'b0000;
        wdata_o    = '0;
        rdata_o    = '0;
        misalign_o = 1'b0;
        case (size)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_raw_i[7:0]}};
                rdata_o = funct3_i[2] ? {24'b0, byte_lane}
                                      : {{24{byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                misalign_o = addr_lo_i[0];
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_raw_i[15:0]}};
                rdata_o    = funct3_i[2] ? {16'b0, half_lane}
                                         : {{16{half_lane[15]}}, half_lane};
            end
            default: begin
                misalign_o = |addr_lo_i;
                be_o       = 4'b1111;
                wdata_o    = wdata_raw_i;
                rdata_o    = rdata_raw_i;
            end
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: turns load/store instructions into one bus transaction,
// stalls the core meanwhile and hands formatted load data to writeback.
//
// state   | meaning
// IDLE    | no transaction; aligned memory op stalls and launches next edge
// BUSY    | request on the bus, waiting for ack or timeout
// DONE    | transaction finished, instruction retires this cycle
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] alu_result_i,
    input  logic [REG_W-1:0] rs2_val_i,
    input  logic [2:0]       funct3_i,
    input  logic             mem_re_i,
    input  logic             mem_we_i,
    output logic             stall_o,
    riscv_lsu_if.master      mem_if,
    output logic [MEM_W-1:0] data_o,
    output logic [REG_W-1:0] data_addr_o,
    output logic             data_re_o,
    output logic             misalign_o,
    output logic             bus_err_o
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    lsu_state_e       state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [REG_W-1:0] addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [MEM_W-1:0] wdata_q, wdata_d;
    logic [1:0]       lane_q, lane_d;
    logic [2:0]       f3_q, f3_d;
    logic             load_q, load_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [MEM_W-1:0] data_q, data_d;
    logic             data_re_q, data_re_d;
    logic             bus_err_q, bus_err_d;

    logic             in_idle;
    logic             mem_op;
    logic             start;
    logic [1:0]       al_lane;
    logic [2:0]       al_f3;
    logic [3:0]       al_be;
    logic [MEM_W-1:0] al_wdata;
    logic [MEM_W-1:0] al_rdata;
    logic             al_misalign;

    // In IDLE the aligner sees the live instruction (store side); once the
    // request is out it sees the latched lane/funct3 (load side).
    assign in_idle = (state_q == ST_IDLE);
    assign al_lane = in_idle ? alu_result_i[1:0] : lane_q;
    assign al_f3   = in_idle ? funct3_i : f3_q;

    riscv_lsu_align u_align (
        .addr_lo_i   (al_lane),
        .funct3_i    (al_f3),
        .wdata_raw_i (rs2_val_i),
        .rdata_raw_i (mem_if.mem_rdata),
        .be_o        (al_be),
        .wdata_o     (al_wdata),
        .rdata_o     (al_rdata),
        .misalign_o  (al_misalign)
    );

    assign mem_op = mem_re_i | mem_we_i;
    assign start  = in_idle & mem_op & ~al_misalign;

    // Stall and misalign follow the instruction combinationally; reset
    // masks them so an abandoned transaction releases the core at once.
    assign stall_o     = ~rst & (start | (state_q == ST_BUSY));
    assign misalign_o  = ~rst & in_idle & mem_op & al_misalign;
    assign data_addr_o = alu_result_i;

    assign mem_if.mem_req   = req_q;
    assign mem_if.mem_we    = we_q;
    assign mem_if.mem_addr  = addr_q;
    assign mem_if.mem_be    = be_q;
    assign mem_if.mem_wdata = wdata_q;
    assign data_o           = data_q;
    assign data_re_o        = data_re_q;
    assign bus_err_o        = bus_err_q;

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        lane_d    = lane_q;
        f3_d      = f3_q;
        load_d    = load_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        data_re_d = 1'b0;
        bus_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                    req_d   = 1'b1;
                    we_d    = mem_we_i;
                    addr_d  = {alu_result_i[REG_W-1:2], 2'b00};
                    be_d    = al_be;
                    wdata_d = al_wdata;
                    lane_d  = alu_result_i[1:0];
                    f3_d    = funct3_i;
                    load_d  = mem_re_i;
                    cnt_d   = 8'd0;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 8'd1;
                // Ack is checked first so it wins over a coincident timeout.
                if (mem_if.mem_ack) begin
                    state_d   = ST_DONE;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    data_re_d = load_q;
                    if (load_q) begin
                        data_d = al_rdata;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ST_DONE;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    data_re_d = load_q;
                    data_d    = '0;
                    bus_err_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= 4'b0000;
            wdata_q   <= '0;
            lane_q    <= 2'b00;
            f3_q      <= 3'b000;
            load_q    <= 1'b0;
            cnt_q     <= 8'd0;
            data_q    <= '0;
            data_re_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            lane_q    <= lane_d;
            f3_q      <= f3_d;
            load_q    <= load_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            data_re_q <= data_re_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized bench for riscv_lsu against an arithmetic reference model.
module tb_riscv_lsu;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] rs2_val = '0;
    logic [2:0]  funct3 = '0;
    logic        mem_re = 1'b0;
    logic        mem_we = 1'b0;
    logic        stall_o;
    logic [31:0] data_o;
    logic [31:0] data_addr_o;
    logic        data_re_o;
    logic        misalign_o;
    logic        bus_err_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_data = '0;

    riscv_lsu_if mem_bus ();

    riscv_lsu #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_result_i (alu_result),
        .rs2_val_i    (rs2_val),
        .funct3_i     (funct3),
        .mem_re_i     (mem_re),
        .mem_we_i     (mem_we),
        .stall_o      (stall_o),
        .mem_if       (mem_bus),
        .data_o       (data_o),
        .data_addr_o  (data_addr_o),
        .data_re_o    (data_re_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: sizes in bytes, masks and lane shifts by arithmetic.
    function automatic int acc_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic m_misalign(input logic [31:0] addr, input logic [2:0] f3);
        return (addr % acc_bytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] m_be(input logic [31:0] addr, input logic [2:0] f3);
        int mask;
        mask = ((1 << acc_bytes(f3)) - 1) << (addr % 4);
        return 32'(mask & 15);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] rs2, input logic [2:0] f3);
        if (acc_bytes(f3) == 1) return (rs2 % 256) * 32'h0101_0101;
        if (acc_bytes(f3) == 2) return (rs2 % 65536) * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] addr,
                                           input logic [2:0] f3);
        logic [31:0] v;
        v = rd >> (8 * (addr % 4));
        if (acc_bytes(f3) == 1) begin
            v = v % 256;
            if (!f3[2] && v >= 128) v = v - 256;
        end else if (acc_bytes(f3) == 2) begin
            v = v % 65536;
            if (!f3[2] && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    // kind: 0 = ALU op, 1 = load, 2 = store. waits < 0 means never ack.
    task automatic run_op(input int kind, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [2:0] f3, input logic [31:0] rdata, input int waits);
        logic        is_load, is_mem, mis, ack_now, done, stable, timed_out, seen_we;
        int          held, stalls, errs, exp_held;
        logic [31:0] seen_addr, seen_be, seen_wd;
        @(negedge clk);
        alu_result = addr;
        rs2_val    = rs2;
        funct3     = f3;
        mem_re     = (kind == 1);
        mem_we     = (kind == 2);
        mem_bus.mem_ack   = (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_bus.mem_rdata = $urandom;
        #1;
        is_mem  = (kind != 0);
        is_load = (kind == 1);
        mis     = is_mem && m_misalign(addr, f3);
        chk("addr_pass", data_addr_o, addr);
        if (!is_mem || mis) begin
            chk("misalign", 32'(misalign_o), 32'(mis));
            chk("stall_nomem", 32'(stall_o), 32'd0);
            @(posedge clk);
            #1;
            chk("req_nomem", 32'(mem_bus.mem_req), 32'd0);
            chk("data_re_nomem", 32'(data_re_o), 32'd0);
            mem_bus.mem_ack = 1'b0;
            return;
        end
        chk("stall_start", 32'(stall_o), 32'd1);
        chk("misalign_ok", 32'(misalign_o), 32'd0);
        held = 0; stalls = 1; errs = 0; stable = 1'b1; done = 1'b0;
        seen_addr = '0; seen_be = '0; seen_wd = '0; seen_we = 1'b0;
        for (int k = 0; k < TO + 40 && !done; k++) begin
            @(negedge clk);
            ack_now = (waits >= 0) && (k == waits);
            mem_bus.mem_ack   = ack_now;
            mem_bus.mem_rdata = ack_now ? rdata : $urandom;
            #1;
            if (bus_err_o) errs++;
            if (mem_bus.mem_req) begin
                if (held == 0) begin
                    seen_we   = mem_bus.mem_we;
                    seen_addr = mem_bus.mem_addr;
                    seen_be   = 32'(mem_bus.mem_be);
                    seen_wd   = mem_bus.mem_wdata;
                end else if (mem_bus.mem_we !== seen_we || mem_bus.mem_addr !== seen_addr ||
                             32'(mem_bus.mem_be) !== seen_be || mem_bus.mem_wdata !== seen_wd) begin
                    stable = 1'b0;
                end
                held++;
            end
            if (stall_o) stalls++;
            else done = 1'b1;
        end
        mem_bus.mem_ack = 1'b0;
        if (!done) begin
            chk("done_bound", 32'd0, 32'd1);
            return;
        end
        timed_out = (waits < 0) || (waits >= TO);
        exp_held  = timed_out ? TO : waits + 1;
        chk("req_cycles", held, exp_held);
        chk("stall_cycles", stalls, exp_held + 1);
        chk("bus_err", errs, timed_out ? 1 : 0);
        chk("bus_stable", 32'(stable), 32'd1);
        chk("bus_addr", seen_addr, addr & ~32'd3);
        chk("bus_we", 32'(seen_we), 32'(kind == 2));
        chk("bus_be", seen_be, m_be(addr, f3));
        if (kind == 2) chk("bus_wdata", seen_wd, m_wdata(rs2, f3));
        chk("data_re", 32'(data_re_o), 32'(is_load));
        if (timed_out) last_data = '0;
        else if (is_load) last_data = m_load(rdata, addr, f3);
        chk("data_o", data_o, last_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ld_f3 [5];
        int         kind, r, waits;
        logic [2:0] f3;
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        #1 rst = 1'b1;
        #2;
        chk("rst_req", 32'(mem_bus.mem_req), 32'd0);
        chk("rst_we", 32'(mem_bus.mem_we), 32'd0);
        chk("rst_addr", mem_bus.mem_addr, 32'd0);
        chk("rst_be", 32'(mem_bus.mem_be), 32'd0);
        chk("rst_wdata", mem_bus.mem_wdata, 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_flags", {28'd0, data_re_o, misalign_o, bus_err_o, stall_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(1, 32'h0000_0100, 32'h0, 3'b010, 32'hDEAD_BEEF, 0);
        chk("lw_lit", data_o, 32'hDEAD_BEEF);
        run_op(1, 32'h0000_0103, 32'h0, 3'b000, 32'h80FF_FF00, 1);
        chk("lb_lit", data_o, 32'hFFFF_FF80);
        run_op(1, 32'h0000_0103, 32'h0, 3'b100, 32'h80FF_FF00, 0);
        chk("lbu_lit", data_o, 32'h0000_0080);
        run_op(2, 32'h0000_0202, 32'h1234_ABCD, 3'b001, 32'h0, 3);
        run_op(1, 32'h0000_0101, 32'h0, 3'b010, 32'h0, 0);
        run_op(1, 32'h0000_0200, 32'h0, 3'b010, 32'h1111_2222, -1);
        chk("timeout_data", data_o, 32'd0);
        run_op(1, 32'h0000_0302, 32'h0, 3'b001, 32'h8001_7FFF, TO - 1);
        run_op(0, 32'h0000_0055, 32'h0, 3'b000, 32'h0, 0);

        // Reset during the second BUSY cycle of a load that never gets acked.
        @(negedge clk);
        alu_result = 32'h0000_0400; funct3 = 3'b010; mem_re = 1'b1; mem_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_pre_req", 32'(mem_bus.mem_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_req_async", 32'(mem_bus.mem_req), 32'd0);
        chk("rst_stall_async", 32'(stall_o), 32'd0);
        alu_result = 32'h0000_0055; mem_re = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_data = '0;
        #1;
        chk("post_rst_addr", data_addr_o, 32'h0000_0055);
        chk("post_rst_data_re", 32'(data_re_o), 32'd0);
        chk("post_rst_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_req", 32'(mem_bus.mem_req), 32'd0);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            if (kind == 1) f3 = ld_f3[$urandom_range(0, 4)];
            else if (kind == 2) f3 = 3'($urandom_range(0, 2));
            else f3 = 3'($urandom);
            r = $urandom_range(0, 9);
            if (r < 6) waits = $urandom_range(0, 3);
            else if (r == 6) waits = TO - 1;
            else if (r == 7) waits = -1;
            else if (r == 8) waits = TO;
            else waits = $urandom_range(4, 8);
            run_op(kind, $urandom, $urandom, f3, $urandom, waits);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
